// File: rtl/serial_binadd.sv
// Bit-serial unsigned adder: LSB-first, one full-adder step per clock through a
// single registered carry; result and carry-out are published when entering DONE.
module serial_binadd #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;

    logic sum_bit;
    logic carry_next;

    assign sum_bit    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign carry_next = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    sum_sh_d = '0;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH steps.
                sum_sh_d = {sum_bit, sum_sh_q[WIDTH-1:1]};
                carry_d  = carry_next;
                if (cnt_q == LAST) begin
                    s_d     = {sum_bit, sum_sh_q[WIDTH-1:1]};
                    cout_d  = carry_next;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            s_q      <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q == RUN) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_binadd.sv
// Directed bench for serial_binadd (WIDTH=4): single ops, carry cases, input
// changes during RUN, back-to-back starts, asynchronous reset abort, full sweep.
module tb_serial_binadd;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [W:0] last_sum = '0;

    serial_binadd #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation with a one-cycle start; optionally changes a/b and pulses
    // start again during RUN at wait index change_at.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input int change_at, input logic [W-1:0] na, input logic [W-1:0] nb);
        logic [W:0] exp_sum;
        int n;
        int busy_cycles;
        exp_sum = {1'b0, oa} + {1'b0, ob};
        a = oa;
        b = ob;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        busy_cycles = 0;
        while (!done && n < 20) begin
            check("hold_prev_result", {27'd0, cout, s}, {27'd0, last_sum});
            if (busy) busy_cycles++;
            start = 1'b0;
            if (n == change_at) begin
                a = na;
                b = nb;
                start = 1'b1;
            end
            tick();
            n++;
        end
        start = 1'b0;
        if (busy) busy_cycles++;
        check("latency", n, W);
        check("busy_cycles", busy_cycles, W + 1);
        check("sum", {27'd0, cout, s}, {27'd0, exp_sum});
        if (done) done_cnt++;
        last_sum = exp_sum;
        tick();
        check("done_single", {31'd0, done}, 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int done_at[$];
        int cyc;
        logic saw_done;

        rst_n = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_s", {28'd0, s}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Basic add; then two carry-out cases with the previous result held during RUN.
        run_op(4'b0001, 4'b0011, -1, 4'b0000, 4'b0000);
        check("basic_s", {28'd0, s}, 32'b0100);
        run_op(4'b1111, 4'b0001, -1, 4'b0000, 4'b0000);
        check("ovf1_s", {27'd0, cout, s}, {27'd0, 5'b10000});
        run_op(4'b1111, 4'b1101, -1, 4'b0000, 4'b0000);
        check("ovf2_s", {27'd0, cout, s}, {27'd0, 5'b11100});

        // Operand changes and a start pulse during RUN must be ignored.
        run_op(4'b0101, 4'b1011, 1, 4'b1111, 4'b1111);
        check("chg_s", {27'd0, cout, s}, {27'd0, 5'b10000});
        tick();
        tick();
        check("no_restart", {31'd0, busy}, 32'd0);

        // start held high: accepts at edges 1,7,13,19 give dones at 5,11,17,23.
        a = 4'b1001;
        b = 4'b0011;
        for (int i = 1; i <= 30; i++) begin
            start = (i <= 20);
            tick();
            if (done) begin
                done_at.push_back(i);
                check("b2b_s", {27'd0, cout, s}, {27'd0, 5'b01100});
            end
        end
        start = 1'b0;
        check("b2b_count", done_at.size(), 4);
        for (int i = 0; i < done_at.size(); i++) begin
            check("b2b_time", done_at[i], 5 + 6 * i);
        end
        last_sum = 5'b01100;

        // Asynchronous reset in the middle of RUN aborts without a done pulse.
        a = 4'b1101;
        b = 4'b0011;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_s", {28'd0, s}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        #2 rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_abort", {31'd0, saw_done}, 32'd0);
        last_sum = '0;
        run_op(4'b0011, 4'b0011, -1, 4'b0000, 4'b0000);
        check("post_reset_s", {27'd0, cout, s}, {27'd0, 5'b00110});

        // Exhaustive sweep of every operand pair.
        done_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            run_op(v[7:4], v[3:0], -1, 4'b0000, 4'b0000);
        end
        check("sweep_done_count", done_cnt, 256);

        cyc = checks;
        $display("Simulation finished: %0d checks, %0d errors", cyc, errors);
        $finish;
    end

endmodule
